// File: rtl/bp_perf_monitor_if.sv
// Bundles the counting inputs, snapshot handshake and result outputs of the
// branch-predictor performance monitor. The master modport drives events in; the slave modport is the monitor.
interface bp_perf_monitor_if #(
  parameter int N_CH  = 2,
  parameter int CNT_W = 32
);
  logic                    en_i;
  logic                    clr_i;
  logic                    instr_vld_i;
  logic [N_CH-1:0]         br_instr_i;
  logic [N_CH-1:0]         br_miss_i;
  logic                    snap_req_i;
  logic                    snap_ack_i;

  logic [CNT_W-1:0]        instr_cnt_o;
  logic [N_CH*CNT_W-1:0]   br_cnt_o;
  logic [N_CH*CNT_W-1:0]   miss_cnt_o;
  logic [CNT_W-1:0]        snap_instr_o;
  logic [N_CH*CNT_W-1:0]   snap_br_o;
  logic [N_CH*CNT_W-1:0]   snap_miss_o;
  logic                    snap_vld_o;
  logic [N_CH*CNT_W-1:0]   win_miss_o;
  logic                    win_done_o;
  logic [N_CH:0]           ovf_o;
  logic [N_CH-1:0]         proto_err_o;

  modport master (
    output en_i, clr_i, instr_vld_i, br_instr_i, br_miss_i, snap_req_i, snap_ack_i,
    input  instr_cnt_o, br_cnt_o, miss_cnt_o, snap_instr_o, snap_br_o, snap_miss_o,
           snap_vld_o, win_miss_o, win_done_o, ovf_o, proto_err_o
  );

  modport slave (
    input  en_i, clr_i, instr_vld_i, br_instr_i, br_miss_i, snap_req_i, snap_ack_i,
    output instr_cnt_o, br_cnt_o, miss_cnt_o, snap_instr_o, snap_br_o, snap_miss_o,
           snap_vld_o, win_miss_o, win_done_o, ovf_o, proto_err_o
  );
endinterface

// File: rtl/bp_perf_monitor.sv
// Branch-predictor performance monitor: cumulative instruction/branch/miss counters,
// a held snapshot with req/ack handshake, and per-window mispredict totals.
module bp_perf_monitor #(
  parameter int N_CH    = 2,
  parameter int CNT_W   = 32,
  parameter int WIN_LEN = 1024,
  parameter int SAT_EN  = 1
) (
  input logic                clk_i,
  input logic                rst_ni,
  bp_perf_monitor_if.slave   mon
);

  localparam int WIN_W = $clog2(WIN_LEN);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);

  typedef logic [CNT_W-1:0]            cnt_t;
  typedef logic [N_CH-1:0][CNT_W-1:0]  cnt_vec_t;
  typedef enum logic {S_IDLE, S_HOLD}  snap_state_e;

  cnt_t               instr_cnt_q, instr_cnt_d;
  cnt_vec_t           br_cnt_q, br_cnt_d;
  cnt_vec_t           miss_cnt_q, miss_cnt_d;
  cnt_t               snap_instr_q, snap_instr_d;
  cnt_vec_t           snap_br_q, snap_br_d;
  cnt_vec_t           snap_miss_q, snap_miss_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  cnt_vec_t           win_acc_q, win_acc_d;
  cnt_vec_t           win_miss_q, win_miss_d;
  logic               win_done_q, win_done_d;
  logic [N_CH:0]      ovf_q, ovf_d;
  logic [N_CH-1:0]    proto_err_q, proto_err_d;
  snap_state_e        state_q, state_d;

  logic               instr_inc;
  logic               win_wrap;
  logic               snap_cap;
  logic               snap_vld;
  logic [CNT_W:0]     bump_r;
  cnt_vec_t           acc_upd;

  // Returns {overflow, next value}; an all-ones counter either holds or wraps.
  function automatic logic [CNT_W:0] bump(input cnt_t v);
    if (&v) return {1'b1, (SAT_EN != 0) ? v : cnt_t'(0)};
    return {1'b0, v + cnt_t'(1)};
  endfunction

  assign instr_inc = mon.en_i & mon.instr_vld_i;
  assign win_wrap  = instr_inc & ~mon.clr_i & (win_cnt_q == WIN_LAST);

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin : counter_next
    instr_cnt_d = instr_cnt_q;
    br_cnt_d    = br_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    ovf_d       = ovf_q;
    win_cnt_d   = win_cnt_q;
    win_acc_d   = win_acc_q;
    win_miss_d  = win_miss_q;
    win_done_d  = 1'b0;
    bump_r      = '0;
    acc_upd     = win_acc_q;
    // A miss without its branch is a protocol error regardless of enable.
    proto_err_d = proto_err_q | (mon.br_miss_i & ~mon.br_instr_i);

    if (mon.clr_i) begin
      instr_cnt_d = '0;
      br_cnt_d    = '0;
      miss_cnt_d  = '0;
      win_cnt_d   = '0;
      win_acc_d   = '0;
    end else if (mon.en_i) begin
      if (mon.instr_vld_i) begin
        bump_r          = bump(instr_cnt_q);
        instr_cnt_d     = bump_r[CNT_W-1:0];
        ovf_d[N_CH]     = ovf_q[N_CH] | bump_r[CNT_W];
        win_cnt_d       = win_cnt_q + 1'b1;
      end
      for (int k = 0; k < N_CH; k++) begin
        if (mon.br_instr_i[k]) begin
          bump_r      = bump(br_cnt_q[k]);
          br_cnt_d[k] = bump_r[CNT_W-1:0];
          ovf_d[k]    = ovf_d[k] | bump_r[CNT_W];
          if (mon.br_miss_i[k]) begin
            bump_r        = bump(miss_cnt_q[k]);
            miss_cnt_d[k] = bump_r[CNT_W-1:0];
            ovf_d[k]      = ovf_d[k] | bump_r[CNT_W];
            // Window accumulators always saturate, independent of SAT_EN.
            if (!(&win_acc_q[k])) acc_upd[k] = win_acc_q[k] + 1'b1;
          end
        end
      end
      if (win_wrap) begin
        win_miss_d = acc_upd;
        win_acc_d  = '0;
        win_done_d = 1'b1;
      end else begin
        win_acc_d  = acc_upd;
      end
    end
  end

  always_comb begin : snap_fsm_next
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (mon.snap_req_i) state_d = S_HOLD;
      S_HOLD:  if (mon.snap_ack_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin : snap_fsm_out
    snap_vld = (state_q == S_HOLD);
    snap_cap = (state_q == S_IDLE) & mon.snap_req_i;
  end

  // Capture the post-edge counter values so the request cycle's own events are included.
  always_comb begin : snap_next
    snap_instr_d = snap_instr_q;
    snap_br_d    = snap_br_q;
    snap_miss_d  = snap_miss_q;
    if (snap_cap) begin
      snap_instr_d = instr_cnt_d;
      snap_br_d    = br_cnt_d;
      snap_miss_d  = miss_cnt_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_cnt_q  <= '0;
      br_cnt_q     <= '0;
      miss_cnt_q   <= '0;
      snap_instr_q <= '0;
      snap_br_q    <= '0;
      snap_miss_q  <= '0;
      win_cnt_q    <= '0;
      win_acc_q    <= '0;
      win_miss_q   <= '0;
      win_done_q   <= 1'b0;
      ovf_q        <= '0;
      proto_err_q  <= '0;
      state_q      <= S_IDLE;
    end else begin
      instr_cnt_q  <= instr_cnt_d;
      br_cnt_q     <= br_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      snap_instr_q <= snap_instr_d;
      snap_br_q    <= snap_br_d;
      snap_miss_q  <= snap_miss_d;
      win_cnt_q    <= win_cnt_d;
      win_acc_q    <= win_acc_d;
      win_miss_q   <= win_miss_d;
      win_done_q   <= win_done_d;
      ovf_q        <= ovf_d;
      proto_err_q  <= proto_err_d;
      state_q      <= state_d;
    end
  end

  assign mon.instr_cnt_o  = instr_cnt_q;
  assign mon.br_cnt_o     = br_cnt_q;
  assign mon.miss_cnt_o   = miss_cnt_q;
  assign mon.snap_instr_o = snap_instr_q;
  assign mon.snap_br_o    = snap_br_q;
  assign mon.snap_miss_o  = snap_miss_q;
  assign mon.snap_vld_o   = snap_vld;
  assign mon.win_miss_o   = win_miss_q;
  assign mon.win_done_o   = win_done_q;
  assign mon.ovf_o        = ovf_q;
  assign mon.proto_err_o  = proto_err_q;

endmodule

// File: tb/tb_bp_perf_monitor.sv
// Directed bench for bp_perf_monitor: one wide instance plus two 8-bit instances
// (saturating and wrapping) driven by the same stimulus.
module tb_bp_perf_monitor;

  logic       clk_i;
  logic       rst_ni;
  logic       en, clr, vld, req, ack;
  logic [1:0] bi, bm;

  int n_checks = 0;
  int n_fail   = 0;

  bp_perf_monitor_if #(.N_CH(2), .CNT_W(32)) if_m ();
  bp_perf_monitor_if #(.N_CH(2), .CNT_W(8))  if_s ();
  bp_perf_monitor_if #(.N_CH(2), .CNT_W(8))  if_w ();

  assign {if_m.en_i, if_m.clr_i, if_m.instr_vld_i, if_m.br_instr_i, if_m.br_miss_i,
          if_m.snap_req_i, if_m.snap_ack_i} = {en, clr, vld, bi, bm, req, ack};
  assign {if_s.en_i, if_s.clr_i, if_s.instr_vld_i, if_s.br_instr_i, if_s.br_miss_i,
          if_s.snap_req_i, if_s.snap_ack_i} = {en, clr, vld, bi, bm, req, ack};
  assign {if_w.en_i, if_w.clr_i, if_w.instr_vld_i, if_w.br_instr_i, if_w.br_miss_i,
          if_w.snap_req_i, if_w.snap_ack_i} = {en, clr, vld, bi, bm, req, ack};

  bp_perf_monitor #(.N_CH(2), .CNT_W(32), .WIN_LEN(4), .SAT_EN(1)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .mon(if_m));
  bp_perf_monitor #(.N_CH(2), .CNT_W(8), .WIN_LEN(4), .SAT_EN(1)) u_sat (
    .clk_i(clk_i), .rst_ni(rst_ni), .mon(if_s));
  bp_perf_monitor #(.N_CH(2), .CNT_W(8), .WIN_LEN(4), .SAT_EN(0)) u_wrap (
    .clk_i(clk_i), .rst_ni(rst_ni), .mon(if_w));

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic e, input logic c, input logic v, input logic [1:0] b_i,
                       input logic [1:0] b_m, input logic rq, input logic ak);
    en = e; clr = c; vld = v; bi = b_i; bm = b_m; req = rq; ack = ak;
  endtask

  // Outputs are sampled 1 ns after the rising edge, well clear of it.
  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(0, 0, 0, 2'b00, 2'b00, 0, 0);
    repeat (2) cycle();
    check("rst_instr",    if_m.instr_cnt_o, 0);
    check("rst_snap_vld", if_m.snap_vld_o,  0);
    check("rst_win_done", if_m.win_done_o,  0);
    check("rst_ovf",      if_m.ovf_o,       0);
    rst_ni = 1'b1;

    // Basic counting: 10 instructions, ch0 branches on 4, one miss.
    drive(1, 0, 1, 2'b01, 2'b01, 0, 0);
    cycle();
    check("first_edge_instr", if_m.instr_cnt_o,        1);
    check("first_edge_miss0", if_m.miss_cnt_o[31:0],   1);
    for (int i = 1; i < 10; i++) begin
      drive(1, 0, 1, (i < 4) ? 2'b01 : 2'b00, 2'b00, 0, 0);
      cycle();
    end
    check("basic_instr", if_m.instr_cnt_o,       10);
    check("basic_br0",   if_m.br_cnt_o[31:0],    4);
    check("basic_miss0", if_m.miss_cnt_o[31:0],  1);
    check("basic_br1",   if_m.br_cnt_o[63:32],   0);
    check("basic_miss1", if_m.miss_cnt_o[63:32], 0);
    check("basic_win2",  if_m.win_miss_o,        0);

    // Clear wins over a same-cycle increment.
    drive(1, 1, 1, 2'b11, 2'b11, 0, 0);
    cycle();
    check("clr_instr", if_m.instr_cnt_o, 0);
    check("clr_br",    if_m.br_cnt_o,    0);
    check("clr_miss",  if_m.miss_cnt_o,  0);
    check("clr_sat",   if_s.instr_cnt_o, 0);

    // Window of 4: three ch1 misses, then a window with none.
    for (int j = 0; j < 3; j++) begin
      drive(1, 0, 1, 2'b10, 2'b10, 0, 0);
      cycle();
    end
    check("win_pre_done", if_m.win_done_o, 0);
    drive(1, 0, 1, 2'b10, 2'b00, 0, 0);
    cycle();
    check("win1_done",  if_m.win_done_o,         1);
    check("win1_miss1", if_m.win_miss_o[63:32],  3);
    check("win1_miss0", if_m.win_miss_o[31:0],   0);
    drive(1, 0, 1, 2'b00, 2'b00, 0, 0);
    cycle();
    check("win1_pulse_end", if_m.win_done_o,        0);
    check("win1_hold",      if_m.win_miss_o[63:32], 3);
    repeat (2) cycle();
    cycle();
    check("win2_done",  if_m.win_done_o,        1);
    check("win2_miss1", if_m.win_miss_o[63:32], 0);

    // Snapshot at instr_cnt=5 with an instruction and ch0 branch in the request cycle.
    drive(1, 1, 0, 2'b00, 2'b00, 0, 0);
    cycle();
    drive(1, 0, 1, 2'b00, 2'b00, 0, 0);
    repeat (5) cycle();
    check("snap_pre_instr", if_m.instr_cnt_o, 5);
    drive(1, 0, 1, 2'b01, 2'b00, 1, 0);
    cycle();
    check("snap_vld",   if_m.snap_vld_o,       1);
    check("snap_instr", if_m.snap_instr_o,     6);
    check("snap_br0",   if_m.snap_br_o[31:0],  1);
    drive(1, 0, 1, 2'b00, 2'b00, 1, 0);
    repeat (20) cycle();
    check("hold_instr_cnt", if_m.instr_cnt_o,      26);
    check("hold_snap",      if_m.snap_instr_o,     6);
    check("hold_vld",       if_m.snap_vld_o,       1);
    check("hold_br0",       if_m.snap_br_o[31:0],  1);
    drive(1, 0, 0, 2'b00, 2'b00, 0, 1);
    cycle();
    check("ack_vld", if_m.snap_vld_o, 0);
    cycle();
    check("idle_ack_vld", if_m.snap_vld_o, 0);

    // 300 instructions into 8-bit counters: saturate vs wrap.
    drive(1, 1, 0, 2'b00, 2'b00, 0, 0);
    cycle();
    drive(1, 0, 1, 2'b00, 2'b00, 0, 0);
    repeat (300) cycle();
    check("sat_instr",   if_s.instr_cnt_o, 255);
    check("sat_ovf",     if_s.ovf_o,       3'b100);
    check("wrap_instr",  if_w.instr_cnt_o, 44);
    check("wrap_ovf",    if_w.ovf_o,       3'b100);
    check("wide_instr",  if_m.instr_cnt_o, 300);
    check("wide_ovf",    if_m.ovf_o,       0);

    // Miss without branch: flags proto_err (even with en low), never counts.
    drive(0, 0, 0, 2'b00, 2'b10, 0, 0);
    cycle();
    check("proto_en0", if_m.proto_err_o, 2'b10);
    check("proto_nocnt_en0", if_m.miss_cnt_o, 0);
    drive(1, 0, 0, 2'b00, 2'b10, 0, 0);
    cycle();
    check("proto_nocnt_en1", if_m.miss_cnt_o, 0);
    check("proto_nobr",      if_m.br_cnt_o,   0);
    drive(1, 1, 1, 2'b01, 2'b00, 0, 0);
    cycle();
    check("clr2_sat_instr", if_s.instr_cnt_o,  0);
    check("clr2_ovf_kept",  if_s.ovf_o,        3'b100);
    check("clr2_proto",     if_m.proto_err_o,  2'b10);
    check("clr2_br",        if_m.br_cnt_o,     0);
    check("clr2_snap_kept", if_m.snap_instr_o, 6);

    // Async reset while holding a snapshot mid-window.
    drive(1, 0, 1, 2'b01, 2'b01, 0, 0);
    cycle();
    drive(1, 0, 1, 2'b00, 2'b00, 0, 0);
    repeat (3) cycle();
    cycle();
    drive(1, 0, 1, 2'b00, 2'b00, 1, 0);
    cycle();
    drive(1, 0, 0, 2'b00, 2'b00, 0, 0);
    check("pre_rst_vld",   if_m.snap_vld_o,       1);
    check("pre_rst_win0",  if_m.win_miss_o[31:0], 1);
    check("pre_rst_snap",  if_m.snap_instr_o,     6);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_instr",  if_m.instr_cnt_o,  0);
    check("arst_miss",   if_m.miss_cnt_o,   0);
    check("arst_vld",    if_m.snap_vld_o,   0);
    check("arst_snap",   if_m.snap_instr_o, 0);
    check("arst_win",    if_m.win_miss_o,   0);
    check("arst_proto",  if_m.proto_err_o,  0);
    check("arst_ovf",    if_s.ovf_o,        0);
    check("arst_done",   if_m.win_done_o,   0);
    cycle();
    rst_ni = 1'b1;
    drive(1, 0, 1, 2'b00, 2'b00, 0, 0);
    cycle();
    check("post_rst_instr", if_m.instr_cnt_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_perf_monitor.md
BP_PERF_MONITOR -- requirements
Module: bp_perf_monitor

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of independent predictor channels monitored (1..8).
REQ-002 SHALL have parameter CNT_W, default 32, width of every event counter (8..64).
REQ-003 SHALL have parameter WIN_LEN, default 1024, retired-instruction count per sampling window (power of two, >= 4).
REQ-004 SHALL have parameter SAT_EN, default 1: 1 = counters saturate at all-ones, 0 = counters wrap to zero.
REQ-005 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_ni  input  1  asynchronous, active-low reset.
REQ-007 en_i  input  1  counting enable; when low, no counter changes.
REQ-008 clr_i  input  1  synchronous clear of cumulative and window counters.
REQ-009 instr_vld_i  input  1  one instruction retired this cycle.
REQ-010 br_instr_i  input  N_CH  per channel: resolved branch/jump this cycle.
REQ-011 br_miss_i  input  N_CH  per channel: that branch was mispredicted.
REQ-012 snap_req_i  input  1  request snapshot of cumulative counters.
REQ-013 snap_ack_i  input  1  consumer accepts the held snapshot.
REQ-014 instr_cnt_o  output  CNT_W  cumulative retired-instruction count.
REQ-015 br_cnt_o  output  N_CH*CNT_W  cumulative branch count; channel k at bits [k*CNT_W +: CNT_W].
REQ-016 miss_cnt_o  output  N_CH*CNT_W  cumulative mispredict count, same packing.
REQ-017 snap_br_o / snap_miss_o  output  N_CH*CNT_W each  snapshot copies; snap_instr_o  output  CNT_W.
REQ-018 snap_vld_o  output  1  snapshot held and valid.
REQ-019 win_miss_o  output  N_CH*CNT_W  mispredicts in the last completed window; win_done_o  output  1  one-cycle pulse at window end.
REQ-020 ovf_o  output  N_CH+1  sticky overflow flags: bit N_CH = instruction counter, bit k = channel k branch or miss counter.
REQ-021 proto_err_o  output  N_CH  sticky: br_miss_i[k] seen without br_instr_i[k].

Function
REQ-022 Instruction counter SHALL increment by 1 on each cycle with en_i & instr_vld_i.
REQ-023 Channel k branch counter SHALL increment on en_i & br_instr_i[k]; miss counter SHALL increment on en_i & br_instr_i[k] & br_miss_i[k].
REQ-024 br_miss_i[k] without br_instr_i[k] SHALL NOT count and SHALL set proto_err_o[k] (also when en_i low).
REQ-025 Counter updates SHALL be visible on outputs the cycle after the qualifying edge (latency 1).
REQ-026 SAT_EN=1: a counter at all-ones SHALL hold and set its ovf_o bit; SAT_EN=0: it SHALL wrap to 0 and set its ovf_o bit.
REQ-027 clr_i SHALL zero cumulative counters, the window instruction counter, and window miss accumulators; clr_i wins over a same-cycle increment; ovf_o, proto_err_o, snapshot state and win_miss_o SHALL be unaffected.
REQ-028 Snapshot FSM states: IDLE, HOLD. IDLE with snap_req_i -> HOLD; snapshot registers capture the counter values as updated by that same edge (including that cycle's increments, or zeros if clr_i).
REQ-029 In HOLD, snap_vld_o=1 and snapshot outputs SHALL be stable; snap_req_i SHALL be ignored.
REQ-030 HOLD with snap_ack_i -> IDLE next cycle; snap_ack_i in IDLE SHALL be ignored; ack and req in the same HOLD cycle returns to IDLE (no new capture).
REQ-031 Window counter SHALL count qualified retired instructions modulo WIN_LEN; on the edge where it wraps, win_miss_o SHALL load that window's per-channel miss totals (including that cycle's misses), accumulators SHALL restart at 0, win_done_o SHALL pulse for the next cycle only.
REQ-032 Window miss accumulators SHALL saturate at all-ones irrespective of SAT_EN.

Reset
REQ-033 rst_ni low SHALL immediately zero all counters, snapshot registers, win_miss_o, ovf_o, proto_err_o, win_done_o, snap_vld_o and set FSM to IDLE, including mid-HOLD or mid-window.
REQ-034 After rst_ni deasserts, the first counting edge SHALL behave as REQ-022..023 with no dead cycles.

Verification
REQ-035 N_CH=2, en=1, 10 cycles instr_vld=1, br_instr=2'b01 on 4 of them, br_miss=2'b01 on 1 -> instr_cnt=10, br ch0=4, miss ch0=1, ch1 all 0.
REQ-036 CNT_W=8, SAT_EN=1, 300 instr -> instr_cnt=255, ovf_o[N_CH]=1; rerun SAT_EN=0 -> instr_cnt=44, ovf set.
REQ-037 snap_req at instr_cnt=5 with instr_vld same cycle -> snap_instr=6, snap_vld=1; counting 20 more leaves snapshot 6; second req ignored; ack -> snap_vld=0 next cycle.
REQ-038 WIN_LEN=4, 3 misses on ch1 in first 4 instr -> win_done pulse 1 cycle, win_miss ch1=3; next window 0 misses -> win_miss ch1=0.
REQ-039 clr_i with simultaneous increment -> all counters 0 next cycle, ovf/proto_err retained; br_miss=1 with br_instr=0 -> proto_err set, no count.
REQ-040 rst_ni pulsed low asynchronously while in HOLD mid-window -> all outputs 0 before next clock edge, snap_vld=0.
